pwm_capture_module: RTL and testbench

//  Receive-side counterpart of the PWM generator: measures one external PWM input
//  and reports the high time (8-bit duty) and the period in clk cycles, rising edge to rising edge.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_capture_module_sync_edge.sv | 34 +++
 rtl/pwm_capture_module.sv | 120 ++++++++++++
 tb/tb_pwm_capture_module.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM constants, capture FSM encoding and the duty saturation helper.
package pwm_pkg;

  localparam int                    PWM_DUTY_W   = 8;
  localparam int                    PWM_PERIOD   = 256;
  localparam logic [PWM_DUTY_W-1:0] PWM_DUTY_MAX = 8'hFF;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } pwm_state_t;

  // Clamp a counter value (zero-extended to 32 bits) to the 8-bit duty range.
  function automatic logic [PWM_DUTY_W-1:0] sat_duty(input logic [31:0] cnt);
    if (cnt > 32'(PWM_DUTY_MAX)) begin
      return PWM_DUTY_MAX;
    end
    return cnt[PWM_DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_capture_module_sync_edge.sv
// 2-FF synchroniser for an asynchronous level plus registered rise/fall pulses.
// level is delayed to line up with the pulses: during a rise pulse level already reads 1.
module pwm_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
      rise <= sync & ~prev;
      fall <= ~sync & prev;
    end
  end

  assign level = prev;

endmodule

// File: rtl/pwm_capture_module.sv
// Measures high time and rise-to-rise period of one PWM input; static inputs reported by timeout.
// Latency: pwm_in rising edge to valid strobe is 4 clk.
module pwm_capture_module
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 9,
  parameter int TIMEOUT = 300
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pwm_in,
  input  logic                  enable,
  output logic [PWM_DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]      period,
  output logic                  valid,
  output logic                  stuck
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

  logic level;
  logic rise;
  logic fall;

  pwm_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  pwm_state_t       state;
  pwm_state_t       state_nxt;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic             publish;
  logic             timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // A rise always wins over a coincident timeout.
  always_comb begin
    state_nxt = state;
    publish   = 1'b0;
    timeout   = 1'b0;
    if (!enable) begin
      state_nxt = S_WAIT;
    end else if (rise) begin
      publish   = (state == S_LOW);
      state_nxt = S_HIGH;
    end else if (period_cnt == CNT_TO) begin
      timeout   = 1'b1;
      state_nxt = S_WAIT;
    end else begin
      case (state)
        S_WAIT:  state_nxt = S_WAIT;
        S_HIGH:  state_nxt = fall ? S_LOW : S_HIGH;
        S_LOW:   state_nxt = S_LOW;
        default: state_nxt = S_WAIT;
      endcase
    end
  end

  // The rise (or timeout) cycle itself counts as cycle 1 of the next interval,
  // so back-to-back reports are exactly one period (or TIMEOUT) apart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (!enable) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (rise) begin
      period_cnt <= CNT_W'(1);
      high_cnt   <= CNT_W'(1);
    end else if (timeout) begin
      period_cnt <= CNT_W'(1);
      high_cnt   <= '0;
    end else begin
      if (period_cnt != CNT_MAX) begin
        period_cnt <= period_cnt + 1'b1;
      end
      if (level && (high_cnt != CNT_MAX)) begin
        high_cnt <= high_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty   <= '0;
      period <= '0;
      valid  <= 1'b0;
      stuck  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (publish) begin
        duty   <= sat_duty(32'(high_cnt));
        period <= period_cnt;
        stuck  <= 1'b0;
        valid  <= 1'b1;
      end else if (timeout) begin
        duty   <= (state == S_HIGH) ? PWM_DUTY_MAX : '0;
        period <= '0;
        stuck  <= 1'b1;
        valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture_module.sv
// Scoreboard bench for pwm_capture_module: expected reports queued as PWM stimulus is driven.
module tb_pwm_capture_module;

  logic       clk = 1'b0;
  logic       reset;
  logic       pwm_in;
  logic       enable;
  logic [7:0] duty;
  logic [8:0] period;
  logic       valid;
  logic       stuck;

  pwm_capture_module dut (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .enable (enable),
    .duty   (duty),
    .period (period),
    .valid  (valid),
    .stuck  (stuck)
  );

  always #5 clk = ~clk;

  typedef struct {
    int duty;
    int period;
    int stuck;
  } exp_t;

  exp_t sb[$];
  int   vcyc[$];
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   n_valid = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int req);
    n_chk++;
    if (obs == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, req, cyc);
  endtask

  task automatic expect_rep(input int d, input int p, input int s, input int n);
    exp_t e;
    e.duty = d;
    e.period = p;
    e.stuck = s;
    repeat (n) sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pwm_period(input int hi, input int per);
    pwm_in = 1'b1;
    cycles(hi);
    pwm_in = 1'b0;
    cycles(per - hi);
  endtask

  // Spacing between report idx and the one before it.
  task automatic chk_gap(input string tag, input int idx, input int gap);
    if (idx >= 1 && idx < vcyc.size()) chk(tag, vcyc[idx] - vcyc[idx-1], gap);
    else chk({tag, "_present"}, vcyc.size(), idx + 1);
  endtask

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      vcyc.push_back(cyc);
      chk("sb_nonempty", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("duty", int'(duty), mon_e.duty);
        chk("period", int'(period), mon_e.period);
        chk("stuck", int'(stuck), mon_e.stuck);
      end
    end
  end

  int base;
  int rise_cyc;
  int nv0;

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    pwm_in = 1'b0;
    cycles(3);
    chk("rst_duty", int'(duty), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_stuck", int'(stuck), 0);
    reset = 1'b1;
    cycles(2);
    enable = 1'b1;
    cycles(5);

    // Nominal 64/256: first report only after the second rise.
    base = vcyc.size();
    rise_cyc = 0;
    expect_rep(64, 256, 0, 3);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) rise_cyc = cyc;
      pwm_period(64, 256);
    end
    chk("lat_rise_to_valid", (vcyc.size() > base) ? vcyc[base] - rise_cyc : -1, 4);
    chk_gap("gap_256_a", base + 1, 256);
    chk_gap("gap_256_b", base + 2, 256);

    // Input held low: stuck reports every TIMEOUT cycles.
    expect_rep(0, 0, 1, 3);
    cycles(700);
    chk_gap("gap_to_a", base + 3, 300);
    chk_gap("gap_to_b", base + 4, 300);
    chk_gap("gap_to_c", base + 5, 300);

    // 255/256, then input held high: first timeout comes from S_HIGH.
    expect_rep(255, 256, 0, 4);
    expect_rep(255, 0, 1, 1);
    for (int i = 0; i < 4; i++) pwm_period(255, 256);
    pwm_in = 1'b1;
    cycles(450);
    pwm_in = 1'b0;
    cycles(20);

    // High time beyond 255 saturates duty; period stays below TIMEOUT so no timeout fires.
    expect_rep(255, 290, 0, 3);
    for (int i = 0; i < 3; i++) pwm_period(270, 290);

    // Reset 100 clk into a period.
    pwm_in = 1'b1;
    cycles(100);
    reset  = 1'b0;
    pwm_in = 1'b0;
    #1;
    chk("midrst_duty", int'(duty), 0);
    chk("midrst_period", int'(period), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_stuck", int'(stuck), 0);
    cycles(5);
    reset = 1'b1;
    cycles(30);
    expect_rep(100, 200, 0, 2);
    for (int i = 0; i < 3; i++) pwm_period(100, 200);

    // Enable dropped mid-period for 50 clk.
    expect_rep(100, 200, 0, 1);
    pwm_in = 1'b1;
    cycles(60);
    enable = 1'b0;
    nv0 = n_valid;
    cycles(40);
    pwm_in = 1'b0;
    cycles(10);
    chk("dis_no_valid", n_valid - nv0, 0);
    chk("dis_hold_duty", int'(duty), 100);
    chk("dis_hold_period", int'(period), 200);
    chk("dis_hold_stuck", int'(stuck), 0);
    enable = 1'b1;
    cycles(90);
    chk("reen_no_valid", n_valid - nv0, 0);
    base = vcyc.size();
    expect_rep(100, 200, 0, 2);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) rise_cyc = cyc;
      pwm_period(100, 200);
    end
    chk("reen_first_report", (vcyc.size() > base) ? vcyc[base] - rise_cyc : -1, 4);
    cycles(20);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
